// File: rtl/pipe_mux_pkg.sv
// Shared state encoding and parameter helpers for the registered N:1 select.
package pipe_mux_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_mux_n_mux_sel_core.sv
// Combinational N:1 select with out-of-range flag; no state.
module mux_sel_core
  import pipe_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int ERR_ZERO   = 1
) (
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data,
  input  logic [SEL_WIDTH-1:0]             sel,
  output logic [DATA_WIDTH-1:0]            sel_data,
  output logic                             sel_err
);

  // One extra bit so NUM_INPUTS == 2**SEL_WIDTH still fits the compare.
  localparam logic [SEL_WIDTH:0] NUM_W = NUM_INPUTS[SEL_WIDTH:0];

  always_comb begin
    sel_err = ({1'b0, sel} >= NUM_W);
    if (ERR_ZERO != 0) begin
      sel_data = '0;
    end else begin
      sel_data = data[DATA_WIDTH-1:0];
    end
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (sel == SEL_WIDTH'(k)) begin
        sel_data = data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// N:1 select registered behind a valid/ready handshake with a 2-entry head/skid buffer.
//   state    | meaning
//   ST_EMPTY | no beat held
//   ST_ONE   | head holds a beat
//   ST_TWO   | head and skid both hold beats, upstream stalled
module pipe_mux_n
  import pipe_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int ERR_ZERO   = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]             in_sel,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_err,
  output logic                             out_valid,
  input  logic                             out_ready
);

  if (NUM_INPUTS < 2 || SEL_WIDTH < clog2(NUM_INPUTS)) begin : g_param_err
    $error("pipe_mux_n: NUM_INPUTS must be >= 2 and fit in SEL_WIDTH");
  end

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  head_err;
  logic                  skid_err;
  logic                  sel_err;
  logic                  accept;
  logic                  pop;
  logic                  load_head_new;
  logic                  load_head_skid;
  logic                  load_skid;

  mux_sel_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_INPUTS (NUM_INPUTS),
    .SEL_WIDTH  (SEL_WIDTH),
    .ERR_ZERO   (ERR_ZERO)
  ) u_core (
    .data     (in_data),
    .sel      (in_sel),
    .sel_data (sel_data),
    .sel_err  (sel_err)
  );

  // in_ready depends on registered state only, never on out_ready.
  assign in_ready  = rst_n & (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = head_data;
  assign out_err   = head_err;

  always_comb begin
    state_nxt      = state;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt     = ST_ONE;
          load_head_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_head_new = 1'b1;
        end else if (accept) begin
          state_nxt = ST_TWO;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_nxt      = ST_ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data <= '0;
      head_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_head_new) begin
        head_data <= sel_data;
        head_err  <= sel_err;
      end else if (load_head_skid) begin
        head_data <= skid_data;
        head_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= sel_data;
        skid_err  <= sel_err;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed and random checks of pipe_mux_n using per-instance expected-beat queues.
module tb_pipe_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic rst_n4, rst_no;

  logic [255:0] id4;  logic [1:0] isel4; logic iv4, irdy4, oe4, ov4, ordy4; logic [63:0] od4;
  logic [191:0] id3;  logic [1:0] isel3; logic iv3, irdy3, oe3, ov3, ordy3; logic [63:0] od3;
  logic [159:0] id5;  logic [2:0] isel5; logic iv5, irdy5, oe5, ov5, ordy5; logic [31:0] od5;

  pipe_mux_n #(.DATA_WIDTH(64), .NUM_INPUTS(4), .SEL_WIDTH(2), .ERR_ZERO(1)) dut4 (
    .clk(clk), .rst_n(rst_n4), .in_data(id4), .in_sel(isel4), .in_valid(iv4), .in_ready(irdy4),
    .out_data(od4), .out_err(oe4), .out_valid(ov4), .out_ready(ordy4));

  pipe_mux_n #(.DATA_WIDTH(64), .NUM_INPUTS(3), .SEL_WIDTH(2), .ERR_ZERO(1)) dut3 (
    .clk(clk), .rst_n(rst_no), .in_data(id3), .in_sel(isel3), .in_valid(iv3), .in_ready(irdy3),
    .out_data(od3), .out_err(oe3), .out_valid(ov3), .out_ready(ordy3));

  pipe_mux_n #(.DATA_WIDTH(32), .NUM_INPUTS(5), .SEL_WIDTH(3), .ERR_ZERO(1)) dut5 (
    .clk(clk), .rst_n(rst_no), .in_data(id5), .in_sel(isel5), .in_valid(iv5), .in_ready(irdy5),
    .out_data(od5), .out_err(oe5), .out_valid(ov5), .out_ready(ordy5));

  logic [64:0] q4[$];
  logic [64:0] q5[$];
  int acc5 = 0;
  int pops5 = 0;
  logic hold4 = 1'b0, hold5 = 1'b0;
  logic [64:0] hv4, hv5;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {err, data} for a beat; data zero-extended to 64 bits.
  function automatic logic [64:0] exp_beat(input logic [319:0] d, input int sel, input int n, input int w);
    logic [319:0] sh;
    logic [63:0]  m;
    if (sel >= n) return {1'b1, 64'd0};
    sh = d >> (sel * w);
    m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    return {1'b0, sh[63:0] & m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors sample at negedge: pop compared first, then the accepted beat is queued.
  always @(negedge clk) begin
    if (hold4 && ov4) chk("dut4_stall_stable", {oe4, od4}, hv4);
    if (ov4 && ordy4) begin
      chk("dut4_pop_expected", 128'(q4.size() > 0), 128'd1);
      if (q4.size() > 0) chk("dut4_beat", {oe4, od4}, q4.pop_front());
    end
    hold4 = ov4 && !ordy4;
    hv4   = {oe4, od4};
    if (iv4 && irdy4) q4.push_back(exp_beat(id4, int'(isel4), 4, 64));
  end

  always @(negedge clk) begin
    if (hold5 && ov5) chk("dut5_stall_stable", {oe5, 32'd0, od5}, hv5);
    if (ov5 && ordy5) begin
      pops5++;
      chk("dut5_pop_expected", 128'(q5.size() > 0), 128'd1);
      if (q5.size() > 0) chk("dut5_beat", {oe5, 32'd0, od5}, q5.pop_front());
    end
    hold5 = ov5 && !ordy5;
    hv5   = {oe5, 32'd0, od5};
    if (iv5 && irdy5) begin
      q5.push_back(exp_beat(id5, int'(isel5), 5, 32));
      acc5++;
    end
  end

  initial begin
    int cyc;
    rst_n4 = 1'b0; rst_no = 1'b0;
    iv4 = 1'b1; isel4 = '0; ordy4 = 1'b1;
    iv3 = 1'b0; isel3 = '0; ordy3 = 1'b1;
    iv5 = 1'b0; isel5 = '0; ordy5 = 1'b1; id5 = '0;
    for (int k = 0; k < 4; k++) id4[k*64 +: 64] = 64'h1111 * 64'(k + 1);
    for (int k = 0; k < 3; k++) id3[k*64 +: 64] = 64'h1111 * 64'(k + 1);

    // Reset
    #1;
    chk("rst_in_ready", 128'(irdy4), 128'd0);
    chk("rst_out_valid", 128'(ov4), 128'd0);
    chk("rst_out_data", 128'(od4), 128'd0);
    chk("rst_out_err", 128'(oe4), 128'd0);
    tick(); tick();
    chk("rst_hold_in_ready", 128'(irdy4), 128'd0);
    iv4 = 1'b0;
    #3;
    rst_n4 = 1'b1; rst_no = 1'b1;
    tick();
    chk("post_rst_in_ready", 128'(irdy4), 128'd1);
    chk("post_rst_out_valid", 128'(ov4), 128'd0);

    // Streaming, no backpressure
    for (int i = 0; i < 4; i++) begin
      iv4 = 1'b1; isel4 = 2'(i);
      tick();
      chk("stream_valid", 128'(ov4), 128'd1);
      chk("stream_data", 128'(od4), 128'(64'h1111 * 64'(i + 1)));
    end
    iv4 = 1'b0;
    tick();
    chk("stream_drained", 128'(ov4), 128'd0);

    // Backpressure into the skid entry
    ordy4 = 1'b0; iv4 = 1'b1; isel4 = 2'd0;
    tick();
    isel4 = 2'd2;
    tick();
    iv4 = 1'b0;
    chk("bp_in_ready", 128'(irdy4), 128'd0);
    chk("bp_head_data", 128'(od4), 128'h1111);
    tick();
    chk("bp_hold_data", 128'(od4), 128'h1111);
    chk("bp_hold_ready", 128'(irdy4), 128'd0);
    ordy4 = 1'b1;
    tick();
    chk("bp_second_data", 128'(od4), 128'h3333);
    chk("bp_ready_back", 128'(irdy4), 128'd1);
    tick();
    chk("bp_empty", 128'(ov4), 128'd0);

    // Asynchronous reset while two beats are buffered
    ordy4 = 1'b0; iv4 = 1'b1; isel4 = 2'd1;
    tick();
    isel4 = 2'd3;
    tick();
    iv4 = 1'b0;
    chk("pre_rst_full", 128'(irdy4), 128'd0);
    #3;
    rst_n4 = 1'b0;
    q4.delete();
    #1;
    chk("async_rst_valid", 128'(ov4), 128'd0);
    chk("async_rst_ready", 128'(irdy4), 128'd0);
    tick();
    #2;
    rst_n4 = 1'b1; ordy4 = 1'b1;
    tick();
    chk("after_rst_valid_a", 128'(ov4), 128'd0);
    tick();
    chk("after_rst_valid_b", 128'(ov4), 128'd0);
    iv4 = 1'b1; isel4 = 2'd2;
    tick();
    iv4 = 1'b0;
    chk("after_rst_new_data", 128'(od4), 128'h3333);
    chk("after_rst_new_valid", 128'(ov4), 128'd1);
    tick();
    chk("after_rst_empty", 128'(ov4), 128'd0);

    // Out-of-range select on the 3-input instance
    iv3 = 1'b1; isel3 = 2'd3;
    tick();
    chk("oor_valid", 128'(ov3), 128'd1);
    chk("oor_err", 128'(oe3), 128'd1);
    chk("oor_data", 128'(od3), 128'd0);
    isel3 = 2'd1;
    tick();
    chk("inrange_err", 128'(oe3), 128'd0);
    chk("inrange_data", 128'(od3), 128'h2222);
    isel3 = 2'd2;
    tick();
    iv3 = 1'b0;
    chk("top_sel_err", 128'(oe3), 128'd0);
    chk("top_sel_data", 128'(od3), 128'h3333);
    tick();
    chk("oor_empty", 128'(ov3), 128'd0);

    // Random valid/ready on the 32-bit, 5-input instance
    cyc = 0;
    while (acc5 < 10000 && cyc < 60000) begin
      iv5   = ($urandom_range(0, 9) < 7);
      isel5 = 3'($urandom_range(0, 7));
      id5   = {$urandom, $urandom, $urandom, $urandom, $urandom};
      ordy5 = ($urandom_range(0, 9) < 6);
      tick();
      cyc++;
    end
    iv5 = 1'b0; ordy5 = 1'b1;
    cyc = 0;
    while (q5.size() != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    tick();
    chk("rand_accepted", 128'(acc5), 128'd10000);
    chk("rand_drained", 128'(q5.size()), 128'd0);
    chk("rand_pops", 128'(pops5), 128'd10000);
    chk("rand_idle", 128'(ov5), 128'd0);
    chk("dut4_queue_empty", 128'(q4.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
